// File: rtl/ysyx_25020047_lsu_if.sv
// Request/response and data-memory signal bundle for the load/store unit.
// The slave modport is the LSU's view; master is the requester/memory side.
interface ysyx_25020047_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: one request at a time, byte-lane steering for sb, zero-extended lbu,
// rejection of illegal/misaligned requests and an ack timeout. All outputs come from state.
module ysyx_25020047_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  ysyx_25020047_lsu_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic        word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        illegal;
  logic [31:0] lane_word;

  // Illegal size codes have bit 0 set; word accesses must be 4-byte aligned.
  assign illegal = bus.req_size[0] | (bus.req_size[1] & (bus.req_addr[1:0] != 2'b00));

  // Selected byte moved down to bits [7:0] for byte loads.
  assign lane_word = bus.mem_rdata >> {addr_q[1:0], 3'b000};

  // State and transaction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      word_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state: accept in idle, wait for ack or timeout in busy, single response cycle.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          word_d  = bus.req_size[1];
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = illegal;
          state_d = illegal ? StResp : StBusy;
        end
      end
      StBusy: begin
        // Ack takes precedence over a timeout in the same cycle.
        if (bus.mem_ack) begin
          if (!write_q) begin
            rdata_d = word_q ? bus.mem_rdata : {24'b0, lane_word[7:0]};
          end
          state_d = StResp;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.req_ready  = (state_q == StIdle);
    bus.resp_valid = (state_q == StResp);
    bus.resp_err   = (state_q == StResp) & err_q;
    bus.resp_rdata = (state_q == StResp) ? rdata_q : 32'b0;
    bus.mem_req    = (state_q == StBusy);
    bus.mem_we     = 1'b0;
    bus.mem_addr   = 32'b0;
    bus.mem_wdata  = 32'b0;
    bus.mem_wmask  = 4'b0000;
    if (state_q == StBusy) begin
      bus.mem_addr = {addr_q[31:2], 2'b00};
      if (write_q) begin
        bus.mem_we    = 1'b1;
        bus.mem_wmask = word_q ? 4'b1111 : (4'b0001 << addr_q[1:0]);
        bus.mem_wdata = word_q ? wdata_q : {4{wdata_q[7:0]}};
      end
    end
  end

endmodule

// File: doc/ysyx_25020047_lsu.md
# ysyx_25020047_lsu

Load/store unit on the memory side of the execute stage: accepts one data-memory request at a time (address, direction, size, store data) from the execute/control path and drives a word-organised data memory with a valid/ack handshake. Performs byte-lane steering for byte stores and zero-extension for byte loads, and rejects illegal or misaligned requests. Signals completion with a one-cycle response pulse. It serves `lw`, `lbu`, `sw` and `sb`.

## Interface
- `TIMEOUT`, 255: cycles to wait for `mem_ack` before aborting with error; legal range 1..65535.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present; sampled only when `req_ready`=1.
- `req_ready`  out  1  unit idle, can accept.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  2'b00 byte, 2'b10 word; 2'b01/2'b11 illegal.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; byte store uses [7:0].
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load data, valid with `resp_valid`; 0 for stores and errors.
- `resp_err`  out  1  misaligned, illegal size or timeout, valid with `resp_valid`.
- `mem_req`  out  1  memory access pending.
- `mem_we`  out  1  write strobe.
- `mem_addr`  out  32  word address {addr[31:2],2'b00}.
- `mem_wdata`  out  32  lane-steered store data.
- `mem_wmask`  out  4  byte-lane enables.
- `mem_ack`  in  1  memory completed access; `mem_rdata` valid same cycle.
- `mem_rdata`  in  32  word read data.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch write/size/addr/wdata.
  - Legal request: go to BUSY and clear the timeout counter.
  - Illegal size, or word access with addr[1:0]≠0: go to RESP with err=1 and make no memory access.
- BUSY:
  - `mem_req`=1, and `mem_addr`/`mem_we`/`mem_wmask`/`mem_wdata` are held stable until ack.
  - On `mem_ack`, go to RESP. For a load, capture the data on the ack cycle.
  - If there is no ack, increment the counter. When counter = TIMEOUT-1 with no ack, go to RESP with err=1 and rdata=0.
- RESP: `resp_valid`=1 for exactly one cycle, then return to IDLE.
- Stores:
  - Word: mask 4'b1111, wdata = req_wdata.
  - Byte: mask = 4'b0001 << addr[1:0], wdata = {4{req_wdata[7:0]}}.
- Loads:
  - `mem_we`=0, mask 4'b0000.
  - Word: rdata = mem_rdata.
  - Byte: rdata = {24'b0, mem_rdata[8*addr[1:0] +: 8]}.
- `mem_ack` outside BUSY is ignored and changes no state or output.
- Outside BUSY, `mem_req`, `mem_we` and `mem_wmask` are 0. `mem_addr`/`mem_wdata` are don't-care but driven as 0.
- Counter width is 16 bits and never wraps: the transition on reaching TIMEOUT-1 takes precedence.
- Ack arriving in the same cycle as the timeout condition: the ack wins and err=0.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE.
  - `req_ready`=1.
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
  - `mem_req`=0, `mem_we`=0, `mem_wmask`=0, `mem_addr`=0, `mem_wdata`=0.
  - Counter = 0.
- Reset mid-transaction drops `mem_req` immediately and produces no response.
- All outputs are registered or decoded purely from state registers. There is no combinational path from `mem_ack` or `req_*` to any output.
- Request accepted at edge N (IDLE, `req_valid`=1):
  - `mem_req`=1 from cycle N+1.
  - Ack sampled at edge N+k (k≥1) gives `resp_valid` in cycle N+k+1.
  - `req_ready`=1 again in cycle N+k+2.
  - Minimum latency is 2 cycles from accept to `resp_valid`; minimum request interval is 3 cycles.
- Error path: accept at N gives `resp_valid`/`resp_err` in cycle N+1.
- Timeout path: `resp_valid` occurs TIMEOUT+1 cycles after accept.
- `req_*` are ignored while `req_ready`=0.

## Test plan
- Word store then load:
  - sw addr 0x80000010, data 0xDEADBEEF, ack after 1 cycle -> mem_we=1, wmask 4'b1111, mem_addr 0x80000010; one resp_valid, err=0.
  - lw same addr, mem_rdata 0xDEADBEEF -> resp_rdata 0xDEADBEEF.
- Byte store lanes: sb addr 0x80000013, wdata 0x000000A5 -> wmask 4'b1000, mem_wdata 0xA5A5A5A5, mem_addr 0x80000010.
- Byte load: lbu addr 0x80000011, mem_rdata 0x11C3_2233 -> resp_rdata 0x00000022. Repeat for addr[1:0]=0..3.
- Errors, no mem_req asserted in any case, resp_err=1 next cycle:
  - lw addr 0x80000002.
  - req_size 2'b01.
- Timeout: TIMEOUT=4, never ack -> mem_req high 4 cycles, then resp_valid with resp_err=1 and rdata 0. Ack coinciding with the last wait cycle -> err=0.
- Reset while BUSY:
  - assert rst -> mem_req drops asynchronously and no resp_valid follows.
  - After release, stray mem_ack in IDLE is ignored.
  - Next request completes normally.
